// File: rtl/reed_solomon_encoder.sv
// ============================================================================
//  Module      : reed_solomon_encoder
//  Description : Systematic streaming RS encoder over GF(2^8), one byte/clock.
//                Optional synchronous abort port enabled by RS_ENC_CLEAR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reed_solomon_encoder #(
    parameter int         K         = 239,
    parameter int         NPAR      = 16,
    parameter logic [8:0] PRIM_POLY = 9'h11D,
    parameter int         FCR       = 0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef RS_ENC_CLEAR_EN
    input  logic       clear,
`endif
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sop_out,
    output logic       eop_out
);

    // Shift-and-add GF(2^8) product; with a constant b it reduces to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    // Ascending coefficients g[0..NPAR-1] of the monic generator (x+a^FCR)...(x+a^(FCR+NPAR-1)).
    function automatic logic [8*NPAR-1:0] gen_coef();
        logic [8*(NPAR+1)-1:0] g;
        logic [7:0]            root;
        g       = '0;
        g[7:0]  = 8'h01;
        root    = 8'h01;
        for (int i = 0; i < FCR; i++) begin
            root = gf_mul(root, 8'h02);
        end
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) begin
                g[8*j +: 8] = g[8*(j-1) +: 8] ^ gf_mul(g[8*j +: 8], root);
            end
            g[7:0] = gf_mul(g[7:0], root);
            root   = gf_mul(root, 8'h02);
        end
        return g[8*NPAR-1:0];
    endfunction

    localparam logic [8*NPAR-1:0] c_gen     = gen_coef();
    localparam logic [7:0]        c_MSG_END = 8'(K - 1);
    localparam logic [5:0]        c_PAR_END = 6'(NPAR - 1);

    typedef enum logic [0:0] {
        S_MSG = 1'b0,
        S_PAR = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             msg_cnt_q, msg_cnt_d;
    logic [5:0]             par_cnt_q, par_cnt_d;
    logic [NPAR-1:0][7:0]   p_q, p_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [7:0]             w_fb;
    logic                   w_clear;

`ifdef RS_ENC_CLEAR_EN
    assign w_clear = clear;
`else
    assign w_clear = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_MSG;
            msg_cnt_q <= '0;
            par_cnt_q <= '0;
            p_q       <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_cnt_q <= msg_cnt_d;
            par_cnt_q <= par_cnt_d;
            p_q       <= p_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
        end
    end

    always_comb begin
        w_fb      = data_in ^ p_q[NPAR-1];
        state_d   = state_q;
        msg_cnt_d = msg_cnt_q;
        par_cnt_d = par_cnt_q;
        p_d       = p_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;

        if (w_clear) begin
            state_d   = S_MSG;
            msg_cnt_d = '0;
            par_cnt_d = '0;
            p_d       = '0;
            data_d    = '0;
        end else begin
            case (state_q)
                S_MSG: begin
                    if (valid_in) begin
                        p_d[0] = gf_mul(w_fb, c_gen[7:0]);
                        for (int i = 1; i < NPAR; i++) begin
                            p_d[i] = p_q[i-1] ^ gf_mul(w_fb, c_gen[8*i +: 8]);
                        end
                        data_d  = data_in;
                        valid_d = 1'b1;
                        sop_d   = (msg_cnt_q == 8'h00);
                        if (msg_cnt_q == c_MSG_END) begin
                            msg_cnt_d = '0;
                            state_d   = S_PAR;
                        end else begin
                            msg_cnt_d = msg_cnt_q + 8'h01;
                        end
                    end
                end
                S_PAR: begin
                    // Remainder drains highest-degree coefficient first.
                    data_d  = p_q[NPAR-1];
                    valid_d = 1'b1;
                    p_d     = {p_q[NPAR-2:0], 8'h00};
                    if (par_cnt_q == c_PAR_END) begin
                        eop_d     = 1'b1;
                        par_cnt_d = '0;
                        p_d       = '0;
                        state_d   = S_MSG;
                    end else begin
                        par_cnt_d = par_cnt_q + 6'h01;
                    end
                end
                default: begin
                    state_d = S_MSG;
                end
            endcase
        end
    end

    assign ready_out = (state_q == S_MSG);
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;

endmodule

`default_nettype wire
